vr_tx_arb: RTL and testbench
============================

VR_TX_ARB -- requirements
Module: vr_tx_arb

Interface
REQ-001 SHALL have parameter NOC_DATA_W, default -1, meaning data bus width in bits, set by the instantiator.
REQ-002 SHALL have parameter NOC_PADBYTES, default NOC_DATA_W/8, meaning bytes per data beat.
REQ-003 SHALL have parameter NOC_PADBYTES_W, default $clog2(NOC_PADBYTES), meaning padbytes field width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  the single clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 src_tx_meta_val  input  2  per-source meta valid; index 0 is the prepare engine, index 1 is the commit engine.
REQ-008 src_tx_meta_info  input  udp_info[1:0]  per-source UDP header info.
REQ-009 tx_src_meta_rdy  output  2  per-source meta ready.
REQ-010 src_tx_data_val  input  2  per-source data valid.
REQ-011 src_tx_data  input  2*NOC_DATA_W  per-source data beat; source i occupies slice i.
REQ-012 src_tx_data_last  input  2  per-source last beat.
REQ-013 src_tx_data_padbytes  input  2*NOC_PADBYTES_W  per-source padbytes.
REQ-014 tx_src_data_rdy  output  2  per-source data ready.
REQ-015 tx_udp_meta_val / tx_udp_meta_info  output  1 / udp_info  merged meta to the UDP transmit path.
REQ-016 udp_tx_meta_rdy  input  1  meta ready from the UDP transmit path.
REQ-017 tx_udp_data_val / tx_udp_data / tx_udp_data_last / tx_udp_data_padbytes  output  1 / NOC_DATA_W / 1 / NOC_PADBYTES_W  merged data stream.
REQ-018 udp_tx_data_rdy  input  1  data ready from the UDP transmit path.
REQ-019 tx_arb_busy  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement a state machine with three states: IDLE, META, DATA.
REQ-021 IDLE: all val and rdy outputs SHALL be 0. If any src_tx_meta_val bit is 1, the block SHALL latch grant_reg and go to META on the next cycle.
REQ-022 Round-robin selection: with both sources requesting, the grant SHALL go to the source not in last_grant_reg. With one source requesting, the grant SHALL go to that source.
REQ-023 META: tx_udp_meta_val SHALL equal src_tx_meta_val[grant_reg], and tx_udp_meta_info SHALL equal src_tx_meta_info[grant_reg] unmodified. tx_src_meta_rdy[grant_reg] SHALL equal udp_tx_meta_rdy; the other bit SHALL be 0.
REQ-024 On a META handshake (val & rdy), the block SHALL go to DATA and set last_grant_reg to grant_reg.
REQ-025 DATA: tx_udp_data* SHALL mirror the src_tx_data* slice of grant_reg. tx_src_data_rdy[grant_reg] SHALL equal udp_tx_data_rdy; the other bit SHALL be 0. No meta SHALL be accepted.
REQ-026 DATA: a handshake with last=1 SHALL return the block to IDLE. The earliest next grant is 1 cycle later, giving a 2-cycle bubble between packets.
REQ-027 The grant SHALL NOT change from the META entry until the last beat completes, even if the other source raises val.
REQ-028 Data beats from a source whose packet is not granted SHALL be stalled (rdy=0) and never dropped.
REQ-029 Pass-through SHALL be combinational with zero added latency on val, data and rdy in META and DATA.
REQ-030 A single-beat packet (last on the first beat) SHALL complete DATA in one handshake.
REQ-031 Backpressure (udp rdy=0) SHALL hold state and grant indefinitely.

Reset
REQ-032 On rst the block SHALL set state to IDLE, last_grant_reg to 1 (source 0 wins the first arbitration) and grant_reg to 0.
REQ-033 During and after rst, all val, rdy and busy outputs SHALL be 0.
REQ-034 A reset asserted mid-packet SHALL abandon the packet with no further beats forwarded; upstream sources are reset in the same cycle.

Verification
REQ-035 Only src0 sends a 3-beat packet with data_length=40 -> meta forwarded unchanged, 3 beats forwarded, busy falls after the last handshake, last_grant=0.
REQ-036 Both sources raise meta_val in the same cycle after reset -> src0's packet is sent first, then src1's, then src0 again (strict alternation over 6 packets).
REQ-037 src1 raises val mid-way through a src0 4-beat packet -> src1 rdy stays 0 until src0's last beat, and src1's meta appears 2 cycles later.
REQ-038 udp_tx_data_rdy is held low 5 cycles on beat 2 -> output is stable, no duplicated or dropped beat, padbytes on the last beat are preserved.
REQ-039 rst is pulsed during beat 2 of a src1 packet -> next cycle state=IDLE with all val/rdy 0, and the next arbitration favours src0.

Source files
------------

// File: rtl/vr_tx_arb_if.sv
// UDP header info type and the bundled source/UDP handshake interface for vr_tx_arb.
// The slave modport is the arbiter; the master modport is the surrounding sources and UDP sink.
package vr_tx_arb_pkg;
   typedef struct packed {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] data_length;
   } udp_info;
endpackage

interface vr_tx_arb_if #(
   parameter int NOC_DATA_W     = -1,
   parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
   parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
);
   import vr_tx_arb_pkg::*;

   // Per-source request side, index 0 = prepare engine, index 1 = commit engine
   logic [1:0]                    src_tx_meta_val;
   udp_info [1:0]                 src_tx_meta_info;
   logic [1:0]                    tx_src_meta_rdy;
   logic [1:0]                    src_tx_data_val;
   logic [2*NOC_DATA_W-1:0]       src_tx_data;
   logic [1:0]                    src_tx_data_last;
   logic [2*NOC_PADBYTES_W-1:0]   src_tx_data_padbytes;
   logic [1:0]                    tx_src_data_rdy;

   // Merged stream towards the UDP transmit path
   logic                          tx_udp_meta_val;
   udp_info                       tx_udp_meta_info;
   logic                          udp_tx_meta_rdy;
   logic                          tx_udp_data_val;
   logic [NOC_DATA_W-1:0]         tx_udp_data;
   logic                          tx_udp_data_last;
   logic [NOC_PADBYTES_W-1:0]     tx_udp_data_padbytes;
   logic                          udp_tx_data_rdy;

   modport slave (
      input  src_tx_meta_val, src_tx_meta_info, src_tx_data_val, src_tx_data,
             src_tx_data_last, src_tx_data_padbytes, udp_tx_meta_rdy, udp_tx_data_rdy,
      output tx_src_meta_rdy, tx_src_data_rdy, tx_udp_meta_val, tx_udp_meta_info,
             tx_udp_data_val, tx_udp_data, tx_udp_data_last, tx_udp_data_padbytes
   );

   modport master (
      output src_tx_meta_val, src_tx_meta_info, src_tx_data_val, src_tx_data,
             src_tx_data_last, src_tx_data_padbytes, udp_tx_meta_rdy, udp_tx_data_rdy,
      input  tx_src_meta_rdy, tx_src_data_rdy, tx_udp_meta_val, tx_udp_meta_info,
             tx_udp_data_val, tx_udp_data, tx_udp_data_last, tx_udp_data_padbytes
   );
endinterface

// File: rtl/vr_tx_arb.sv
// Two-source round-robin packet arbiter in front of the UDP transmit path.
// A grant is held from meta acceptance through the last data beat; all handshakes pass through combinationally.
module vr_tx_arb #(
   parameter int NOC_DATA_W     = -1,
   parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
   parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
) (
   input  logic          clk,
   input  logic          rst,
   vr_tx_arb_if.slave    bus,
   output logic          tx_arb_busy
);

   typedef enum logic [1:0] {IDLE, META, DATA} state_e;

   state_e state_q, state_d;
   logic   grant_q, grant_d;
   logic   last_grant_q, last_grant_d;
   logic   busy_q, busy_d;

   logic   in_meta;
   logic   in_data;
   logic   meta_hs;
   logic   last_hs;

   assign meta_hs = bus.src_tx_meta_val[grant_q] & bus.udp_tx_meta_rdy;
   assign last_hs = bus.src_tx_data_val[grant_q] & bus.udp_tx_data_rdy & bus.src_tx_data_last[grant_q];

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            // With both sources waiting, the one served less recently wins
            if (|bus.src_tx_meta_val) begin
               grant_d = (&bus.src_tx_meta_val) ? ~last_grant_q : bus.src_tx_meta_val[1];
               state_d = META;
            end
         end
         META: begin
            if (meta_hs) begin
               state_d      = DATA;
               last_grant_d = grant_q;
            end
         end
         DATA: begin
            if (last_hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
      end
   end

   // Outputs are forced quiet while reset is held so an abandoned packet never leaks a beat
   assign in_meta     = (state_q == META) & ~rst;
   assign in_data     = (state_q == DATA) & ~rst;
   assign tx_arb_busy = busy_q & ~rst;

   always_comb begin
      bus.tx_src_meta_rdy      = 2'b00;
      bus.tx_src_data_rdy      = 2'b00;
      bus.tx_udp_meta_val      = in_meta & bus.src_tx_meta_val[grant_q];
      bus.tx_udp_meta_info     = bus.src_tx_meta_info[grant_q];
      bus.tx_udp_data_val      = in_data & bus.src_tx_data_val[grant_q];
      bus.tx_udp_data          = grant_q ? bus.src_tx_data[2*NOC_DATA_W-1:NOC_DATA_W]
                                         : bus.src_tx_data[NOC_DATA_W-1:0];
      bus.tx_udp_data_last     = bus.src_tx_data_last[grant_q];
      bus.tx_udp_data_padbytes = grant_q ? bus.src_tx_data_padbytes[2*NOC_PADBYTES_W-1:NOC_PADBYTES_W]
                                         : bus.src_tx_data_padbytes[NOC_PADBYTES_W-1:0];
      if (in_meta) begin
         bus.tx_src_meta_rdy[grant_q] = bus.udp_tx_meta_rdy;
      end
      if (in_data) begin
         bus.tx_src_data_rdy[grant_q] = bus.udp_tx_data_rdy;
      end
   end

endmodule

// File: tb/tb_vr_tx_arb.sv
// Self-checking bench for vr_tx_arb: packet-queue sources, a randomised UDP sink and a
// packet-ownership reference model that predicts every handshake output each cycle.
module tb_vr_tx_arb;
   import vr_tx_arb_pkg::*;

   localparam int DW = 64;
   localparam int PW = 3;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [PW-1:0] pad;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   vr_tx_arb_if #(.NOC_DATA_W(DW)) bus ();

   vr_tx_arb #(.NOC_DATA_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .tx_arb_busy (busy)
   );

   always #5 clk = ~clk;

   udp_info    mq [2][$];
   beat_t      bq [2][$];
   udp_info    drv_info [2];
   beat_t      drv_beat [2];
   logic [1:0] mval, dval;
   int         val_pct, mrdy_pct, drdy_pct;
   bit         stall_mode;
   int         stall_cnt, out_beat;
   int         owner;
   bit         hdr;
   int         last_grant;
   int         order [$];
   int         n_cmp, n_bad;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input int s, input int nb, input logic [15:0] len);
      udp_info i;
      beat_t   b;
      i.src_ip      = $urandom;
      i.dst_ip      = $urandom;
      i.src_port    = 16'($urandom);
      i.dst_port    = 16'($urandom);
      i.data_length = len;
      mq[s].push_back(i);
      for (int k = 0; k < nb; k++) begin
         b.data = {$urandom, $urandom};
         b.last = (k == nb - 1);
         b.pad  = b.last ? 3'($urandom_range(7)) : 3'd0;
         bq[s].push_back(b);
      end
   endtask

   // Sources keep val asserted until their handshake; the sink may be random or a directed stall
   task automatic apply_stimulus();
      for (int s = 0; s < 2; s++) begin
         if (!mval[s] && mq[s].size() > 0 && $urandom_range(99) < val_pct) mval[s] = 1'b1;
         if (!dval[s] && bq[s].size() > 0 && $urandom_range(99) < val_pct) dval[s] = 1'b1;
         drv_info[s] = (mq[s].size() > 0) ? mq[s][0] : '0;
         drv_beat[s] = (bq[s].size() > 0) ? bq[s][0] : '0;
         bus.src_tx_meta_info[s]              = drv_info[s];
         bus.src_tx_data[s*DW +: DW]          = drv_beat[s].data;
         bus.src_tx_data_last[s]              = drv_beat[s].last;
         bus.src_tx_data_padbytes[s*PW +: PW] = drv_beat[s].pad;
      end
      bus.src_tx_meta_val = mval;
      bus.src_tx_data_val = dval;
      bus.udp_tx_meta_rdy = ($urandom_range(99) < mrdy_pct);
      if (stall_mode) begin
         bus.udp_tx_data_rdy = !(out_beat == 1 && stall_cnt < 5);
         if (!bus.udp_tx_data_rdy) stall_cnt++;
      end else begin
         bus.udp_tx_data_rdy = ($urandom_range(99) < drdy_pct);
      end
   endtask

   task automatic check_output();
      logic [1:0] e_mrdy, e_drdy;
      logic       e_mval, e_dval, e_busy;
      bit         act;
      e_mrdy = 2'b00; e_drdy = 2'b00; e_mval = 1'b0; e_dval = 1'b0; e_busy = 1'b0;
      act = !rst && owner >= 0;
      if (act) begin
         e_busy = 1'b1;
         if (!hdr) begin
            e_mval         = mval[owner];
            e_mrdy[owner]  = bus.udp_tx_meta_rdy;
         end else begin
            e_dval         = dval[owner];
            e_drdy[owner]  = bus.udp_tx_data_rdy;
         end
      end
      chk("busy", busy, e_busy);
      chk("meta_rdy", bus.tx_src_meta_rdy, e_mrdy);
      chk("data_rdy", bus.tx_src_data_rdy, e_drdy);
      if (!(act && hdr)) chk("meta_val", bus.tx_udp_meta_val, e_mval);
      if (!(act && !hdr)) chk("data_val", bus.tx_udp_data_val, e_dval);
      if (act && !hdr) chk("meta_info", bus.tx_udp_meta_info, drv_info[owner]);
      if (act && hdr) begin
         chk("data", bus.tx_udp_data, drv_beat[owner].data);
         chk("data_last", bus.tx_udp_data_last, drv_beat[owner].last);
         chk("padbytes", bus.tx_udp_data_padbytes, drv_beat[owner].pad);
      end
   endtask

   task automatic advance();
      if (rst) begin
         owner = -1; hdr = 0; last_grant = 1;
         for (int s = 0; s < 2; s++) begin
            mq[s].delete();
            bq[s].delete();
         end
         mval = 2'b00; dval = 2'b00; out_beat = 0; stall_cnt = 0;
         order.delete();
      end else begin
         if (owner < 0) begin
            if (mval == 2'b11)   owner = 1 - last_grant;
            else if (mval[0])    owner = 0;
            else if (mval[1])    owner = 1;
            hdr = 0;
         end else if (!hdr) begin
            if (mval[owner] && bus.udp_tx_meta_rdy) begin
               hdr = 1;
               last_grant = owner;
            end
         end else if (dval[owner] && bus.udp_tx_data_rdy) begin
            if (drv_beat[owner].last) begin
               owner = -1; out_beat = 0; stall_cnt = 0;
            end else begin
               out_beat++;
            end
         end
         for (int s = 0; s < 2; s++) begin
            if (mval[s] && bus.tx_src_meta_rdy[s]) begin
               void'(mq[s].pop_front());
               mval[s] = 1'b0;
               order.push_back(s);
            end
            if (dval[s] && bus.tx_src_data_rdy[s]) begin
               void'(bq[s].pop_front());
               dval[s] = 1'b0;
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      apply_stimulus();
      #1;
      check_output();
      advance();
   endtask

   task automatic drain(input int budget, input string tag);
      int n;
      n = 0;
      while ((mq[0].size() + mq[1].size() + bq[0].size() + bq[1].size() > 0 || owner >= 0) && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, n < budget, 1'b1);
      cycle();
      cycle();
   endtask

   task automatic chk_order(input string tag, input int exp[$]);
      chk({tag, "_count"}, order.size(), exp.size());
      for (int k = 0; k < exp.size() && k < order.size(); k++)
         chk($sformatf("%s_%0d", tag, k), order[k], exp[k]);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int budget;
      n_cmp = 0; n_bad = 0;
      mval = 2'b00; dval = 2'b00; owner = -1; hdr = 0; last_grant = 1;
      val_pct = 100; mrdy_pct = 100; drdy_pct = 100;
      stall_mode = 0; out_beat = 0; stall_cnt = 0;
      bus.src_tx_meta_val = '0; bus.src_tx_meta_info = '0; bus.src_tx_data_val = '0;
      bus.src_tx_data = '0; bus.src_tx_data_last = '0; bus.src_tx_data_padbytes = '0;
      bus.udp_tx_meta_rdy = 1'b0; bus.udp_tx_data_rdy = 1'b0;
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      $display("[TB] single source, 3 beats, data_length 40");
      add_pkt(0, 3, 16'd40);
      drain(50, "drain_single");
      chk_order("order_single", '{0});

      $display("[TB] after src0 packet both request: src1 must win");
      order.delete();
      add_pkt(0, 1, 16'd8);
      add_pkt(1, 1, 16'd8);
      drain(50, "drain_lastgrant");
      chk_order("order_lastgrant", '{1, 0});

      $display("[TB] simultaneous requests after reset alternate strictly");
      pulse_reset();
      for (int k = 0; k < 3; k++) begin
         add_pkt(0, 1 + k, 16'(100 + k));
         add_pkt(1, 2, 16'(200 + k));
      end
      drain(200, "drain_alt");
      chk_order("order_alt", '{0, 1, 0, 1, 0, 1});

      $display("[TB] src1 arrives mid-way through a src0 4-beat packet");
      order.delete();
      add_pkt(0, 4, 16'd64);
      repeat (3) cycle();
      add_pkt(1, 2, 16'd16);
      drain(60, "drain_mid");
      chk_order("order_mid", '{0, 1});

      $display("[TB] sink stalls 5 cycles on beat 2");
      stall_mode = 1;
      add_pkt(0, 3, 16'd24);
      drain(60, "drain_stall");
      stall_mode = 0;

      $display("[TB] reset during beat 2 of a src1 packet");
      add_pkt(1, 4, 16'd32);
      budget = 0;
      while (bq[1].size() != 3 && budget < 30) begin
         cycle();
         budget++;
      end
      chk("reach_beat2", budget < 30, 1'b1);
      pulse_reset();
      add_pkt(1, 2, 16'd12);
      add_pkt(0, 2, 16'd12);
      drain(60, "drain_post_reset");
      chk_order("order_post_reset", '{0, 1});

      $display("[TB] randomised traffic with random backpressure");
      val_pct = 70; mrdy_pct = 60; drdy_pct = 60;
      for (int r = 0; r < 6; r++) begin
         add_pkt($urandom_range(1), $urandom_range(5, 1), 16'($urandom));
         add_pkt($urandom_range(1), $urandom_range(5, 1), 16'($urandom));
         repeat ($urandom_range(12, 2)) cycle();
      end
      drain(3000, "drain_random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
